// File: rtl/ones_comp_pkg.sv
// Shared types and the reference end-around add for the one's-complement accumulator.
package ones_comp_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam int OC_MAX_W = 64;

    // Operands must be zero above bit w-1; the fold into bit 0 never re-overflows.
    function automatic logic [OC_MAX_W-1:0] oc_add(
        input logic [OC_MAX_W-1:0] a,
        input logic [OC_MAX_W-1:0] b,
        input int unsigned         w
    );
        logic [OC_MAX_W:0]   s;
        logic [OC_MAX_W:0]   one;
        logic [OC_MAX_W:0]   mask;
        logic [OC_MAX_W-1:0] r;
        one  = {{OC_MAX_W{1'b0}}, 1'b1};
        s    = {1'b0, a} + {1'b0, b};
        mask = (one << w) - one;
        r    = s[OC_MAX_W-1:0] & mask[OC_MAX_W-1:0];
        return r + {{(OC_MAX_W-1){1'b0}}, s[w[6:0]]};
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/ones_comp_adder.sv
// Combinational one's-complement adder: ripple-carry sum followed by an end-around carry fold.
module ones_comp_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            full_adder u_fa (
                .a   (A[gi]),
                .b   (B[gi]),
                .cin (carry[gi]),
                .s   (sum[gi]),
                .cout(carry[gi+1])
            );
        end
    endgenerate

    // Feeding carry-out back into carry[0] would form a loop; add it as a second stage instead.
    assign Y = sum + {{(WIDTH-1){1'b0}}, carry[WIDTH]};
endmodule

// File: rtl/ones_compliment_accum.sv
// Streaming one's-complement checksum accumulator: valid/ready word input, valid/ready checksum output.
module ones_compliment_accum
    import ones_comp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int CNT_W      = 8,
    parameter bit INVERT_OUT = 1'b1,
    parameter bit NORM_ZERO  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic             A_valid,
    input  logic             A_last,
    input  logic             sub,
    output logic             A_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Y_valid,
    input  logic             Y_ready,
    output logic [CNT_W-1:0] count,
    output logic             count_ovf
);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] norm;
    logic [CNT_W-1:0] count_reg;
    logic             count_ovf_reg;
    logic             a_ready_reg;
    logic             y_valid_reg;
    logic             xfer;

    assign operand = sub ? ~A : A;
    assign xfer    = A_valid && a_ready_reg;

    ones_comp_adder #(.WIDTH(WIDTH)) u_adder (
        .A(acc_reg),
        .B(operand),
        .Y(acc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            count_reg     <= '0;
            count_ovf_reg <= 1'b0;
            a_ready_reg   <= 1'b0;
            y_valid_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg     <= ACCUM;
                        acc_reg       <= '0;
                        count_reg     <= '0;
                        count_ovf_reg <= 1'b0;
                        a_ready_reg   <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc_reg <= acc_next;
                        // Saturate rather than wrap; the sum itself is unaffected.
                        if (count_reg == CNT_MAX) begin
                            count_ovf_reg <= 1'b1;
                        end else begin
                            count_reg <= count_reg + CNT_ONE;
                        end
                        if (A_last) begin
                            state_reg   <= DONE;
                            a_ready_reg <= 1'b0;
                            y_valid_reg <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (Y_ready) begin
                        state_reg   <= IDLE;
                        y_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    a_ready_reg <= 1'b0;
                    y_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign norm = (NORM_ZERO && (acc_reg == ALL_ONES)) ? '0 : acc_reg;

    assign Y         = INVERT_OUT ? ~norm : norm;
    assign A_ready   = a_ready_reg;
    assign Y_valid   = y_valid_reg;
    assign count     = count_reg;
    assign count_ovf = count_ovf_reg;
endmodule

// File: tb/tb_ones_compliment_accum.sv
// Directed-vector bench for ones_compliment_accum: three output-mode variants driven in parallel.
module tb_ones_compliment_accum;
    import ones_comp_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] a = 4'h0;
    logic       a_valid = 1'b0;
    logic       a_last = 1'b0;
    logic       sub = 1'b0;
    logic       y_ready = 1'b0;

    // dut: INVERT_OUT=1 NORM_ZERO=1
    logic       a_ready, y_valid, ovf;
    logic [3:0] y;
    logic [7:0] count;
    // dut_r: INVERT_OUT=0 NORM_ZERO=0 (Y is the raw accumulator)
    logic       a_ready_r, y_valid_r, ovf_r;
    logic [3:0] y_r;
    logic [7:0] count_r;
    // dut_z: INVERT_OUT=0 NORM_ZERO=1
    logic       a_ready_z, y_valid_z, ovf_z;
    logic [3:0] y_z;
    logic [7:0] count_z;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ones_compliment_accum #(.WIDTH(4), .CNT_W(8), .INVERT_OUT(1'b1), .NORM_ZERO(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .A(a), .A_valid(a_valid), .A_last(a_last),
        .sub(sub), .A_ready(a_ready), .Y(y), .Y_valid(y_valid), .Y_ready(y_ready),
        .count(count), .count_ovf(ovf)
    );

    ones_compliment_accum #(.WIDTH(4), .CNT_W(8), .INVERT_OUT(1'b0), .NORM_ZERO(1'b0)) dut_r (
        .clk(clk), .reset(reset), .start(start), .A(a), .A_valid(a_valid), .A_last(a_last),
        .sub(sub), .A_ready(a_ready_r), .Y(y_r), .Y_valid(y_valid_r), .Y_ready(y_ready),
        .count(count_r), .count_ovf(ovf_r)
    );

    ones_compliment_accum #(.WIDTH(4), .CNT_W(8), .INVERT_OUT(1'b0), .NORM_ZERO(1'b1)) dut_z (
        .clk(clk), .reset(reset), .start(start), .A(a), .A_valid(a_valid), .A_last(a_last),
        .sub(sub), .A_ready(a_ready_z), .Y(y_z), .Y_valid(y_valid_z), .Y_ready(y_ready),
        .count(count_z), .count_ovf(ovf_z)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w, input logic last, input logic s);
        int n;
        n = 0;
        while (a_ready !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        if (a_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL a_ready_timeout: a_ready=%b required 1", a_ready);
        end
        a = w; a_valid = 1'b1; a_last = last; sub = s;
        tick();
        a_valid = 1'b0; a_last = 1'b0; sub = 1'b0;
    endtask

    task automatic finish_packet();
        y_ready = 1'b1;
        tick();
        y_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL reset_a_ready: got %b want 0", a_ready); end
        tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL reset_y_valid: got %b want 0", y_valid); end
        tests++; if (count !== 8'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        tests++; if (y !== 4'hF) begin fails++; $display("FAIL reset_y_inv: got %h want f", y); end
        tests++; if (y_r !== 4'h0) begin fails++; $display("FAIL reset_y_raw: got %h want 0", y_r); end
        reset = 1'b0;
        tick();
        tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL reset_idle_hold: a_ready got %b want 0", a_ready); end
        $display("[TB] reset: y=%h y_raw=%h count=%0d", y, y_r, count);
    endtask

    task automatic test_add_pair();
        do_start();
        send_word(4'h5, 1'b0, 1'b0);
        send_word(4'h3, 1'b1, 1'b0);
        tests++; if (y_valid !== 1'b1) begin fails++; $display("FAIL add_y_valid: got %b want 1", y_valid); end
        tests++; if (y !== 4'h7) begin fails++; $display("FAIL add_y: got %h want 7", y); end
        tests++; if (y_r !== 4'h8) begin fails++; $display("FAIL add_y_raw: got %h want 8", y_r); end
        tests++; if (count !== 8'd2) begin fails++; $display("FAIL add_count: got %0d want 2", count); end
        tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL add_a_ready_done: got %b want 0", a_ready); end
        $display("[TB] add 5+3: y=%h raw=%h count=%0d", y, y_r, count);
        finish_packet();
        tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL add_release: y_valid got %b want 0", y_valid); end
    endtask

    task automatic test_end_around();
        do_start();
        send_word(4'hC, 1'b0, 1'b0);
        send_word(4'h6, 1'b1, 1'b0);
        tests++; if (y !== 4'hC) begin fails++; $display("FAIL eac_y: got %h want c", y); end
        tests++; if (y_r !== 4'h3) begin fails++; $display("FAIL eac_y_raw: got %h want 3", y_r); end
        $display("[TB] add C+6: y=%h raw=%h count=%0d", y, y_r, count);
        finish_packet();
    endtask

    task automatic test_subtract();
        do_start();
        send_word(4'h5, 1'b0, 1'b0);
        send_word(4'h3, 1'b1, 1'b1);
        tests++; if (y !== 4'hD) begin fails++; $display("FAIL sub_y: got %h want d", y); end
        tests++; if (y_r !== 4'h2) begin fails++; $display("FAIL sub_y_raw: got %h want 2", y_r); end
        $display("[TB] 5-3: y=%h raw=%h count=%0d", y, y_r, count);
        finish_packet();
    endtask

    task automatic test_neg_zero();
        do_start();
        send_word(4'h5, 1'b0, 1'b0);
        send_word(4'hA, 1'b1, 1'b0);
        tests++; if (y !== 4'hF) begin fails++; $display("FAIL negz_inv_norm: got %h want f", y); end
        tests++; if (y_r !== 4'hF) begin fails++; $display("FAIL negz_raw: got %h want f", y_r); end
        tests++; if (y_z !== 4'h0) begin fails++; $display("FAIL negz_norm_noinv: got %h want 0", y_z); end
        $display("[TB] 5+A: y=%h raw=%h norm=%h", y, y_r, y_z);
        finish_packet();
    endtask

    task automatic test_flow_control();
        do_start();
        send_word(4'h1, 1'b0, 1'b0);
        a_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL gap_a_ready[%0d]: got %b want 1", i, a_ready); end
            tests++; if (y_r !== 4'h1) begin fails++; $display("FAIL gap_acc[%0d]: got %h want 1", i, y_r); end
            tests++; if (count !== 8'd1) begin fails++; $display("FAIL gap_count[%0d]: got %0d want 1", i, count); end
        end
        a_last = 1'b0;
        send_word(4'h2, 1'b1, 1'b0);
        a = 4'hF;
        a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (y_valid !== 1'b1) begin fails++; $display("FAIL bp_y_valid[%0d]: got %b want 1", i, y_valid); end
            tests++; if (y !== 4'hC) begin fails++; $display("FAIL bp_y[%0d]: got %h want c", i, y); end
            tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL bp_a_ready[%0d]: got %b want 0", i, a_ready); end
            tests++; if (count !== 8'd2) begin fails++; $display("FAIL bp_count[%0d]: got %0d want 2", i, count); end
        end
        a_valid = 1'b0;
        $display("[TB] 1,gap,2 with backpressure: y=%h count=%0d", y, count);
        y_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        y_ready = 1'b0;
        tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL handshake_y_valid: got %b want 0", y_valid); end
        tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL handshake_a_ready: got %b want 0", a_ready); end
        tick();
        tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL start_in_done_ignored: a_ready got %b want 0", a_ready); end
    endtask

    task automatic test_back_to_back();
        y_ready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            do_start();
            tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL b2b_accum[%0d]: a_ready got %b want 1", p, a_ready); end
            send_word(4'h4 + 4'(p), 1'b1, 1'b0);
            tests++; if (y_valid !== 1'b1) begin fails++; $display("FAIL b2b_y_valid[%0d]: got %b want 1", p, y_valid); end
            tests++; if (y_r !== 4'h4 + 4'(p)) begin fails++; $display("FAIL b2b_y_raw[%0d]: got %h want %h", p, y_r, 4'h4 + 4'(p)); end
            $display("[TB] single word %0d: raw=%h count=%0d", p, y_r, count);
            tick();
            tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle[%0d]: y_valid got %b want 0", p, y_valid); end
        end
        y_ready = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        do_start();
        send_word(4'h1, 1'b0, 1'b0);
        send_word(4'h2, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL midrst_a_ready: got %b want 0", a_ready); end
        tests++; if (count !== 8'd0) begin fails++; $display("FAIL midrst_count: got %0d want 0", count); end
        tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL midrst_y_valid: got %b want 0", y_valid); end
        tests++; if (y_r !== 4'h0) begin fails++; $display("FAIL midrst_acc: got %h want 0", y_r); end
        $display("[TB] reset mid-packet: count=%0d raw=%h", count, y_r);
    endtask

    task automatic test_saturation();
        logic [3:0] m;
        logic [3:0] t;
        m = 4'h0;
        do_start();
        for (int i = 1; i <= 300; i++) begin
            send_word(4'h1, (i == 300), 1'b0);
            m = 4'(oc_add(64'(m), 64'(4'h1), 4));
            if (i == 255) begin
                tests++; if (count !== 8'd255) begin fails++; $display("FAIL sat_count_255: got %0d want 255", count); end
                tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL sat_ovf_255: got %b want 0", ovf); end
            end
            if (i == 256) begin
                tests++; if (count !== 8'd255) begin fails++; $display("FAIL sat_count_256: got %0d want 255", count); end
                tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL sat_ovf_256: got %b want 1", ovf); end
            end
        end
        t = (m == 4'hF) ? 4'h0 : m;
        tests++; if (y_valid !== 1'b1) begin fails++; $display("FAIL sat_y_valid: got %b want 1", y_valid); end
        tests++; if (y_r !== m) begin fails++; $display("FAIL sat_acc: got %h want %h", y_r, m); end
        tests++; if (y !== ~t) begin fails++; $display("FAIL sat_y: got %h want %h", y, ~t); end
        tests++; if (count !== 8'd255) begin fails++; $display("FAIL sat_count: got %0d want 255", count); end
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL sat_ovf: got %b want 1", ovf); end
        $display("[TB] 300 x 1: y=%h raw=%h count=%0d ovf=%b", y, y_r, count, ovf);
        finish_packet();
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL sat_ovf_idle_hold: got %b want 1", ovf); end
        do_start();
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL sat_ovf_cleared: got %b want 0", ovf); end
        tests++; if (count !== 8'd0) begin fails++; $display("FAIL sat_count_cleared: got %0d want 0", count); end
        send_word(4'h7, 1'b1, 1'b0);
        tests++; if (count !== 8'd1) begin fails++; $display("FAIL post_sat_count: got %0d want 1", count); end
        tests++; if (y_r !== 4'h7) begin fails++; $display("FAIL post_sat_acc: got %h want 7", y_r); end
        $display("[TB] post-saturation single word: raw=%h count=%0d", y_r, count);
        finish_packet();
    endtask

    initial begin
        test_reset();
        test_add_pair();
        test_end_around();
        test_subtract();
        test_neg_zero();
        test_flow_control();
        test_back_to_back();
        test_reset_mid_packet();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ones_compliment_accum.md
Name: ones_compliment_accum

Overview:
Streaming, parametrised one's-complement accumulator with end-around carry. It is the sequential successor to the 4-bit combinational one's-complement adder.
- Accepts a packet of WIDTH-bit words over a valid/ready handshake.
- Adds or subtracts each word into a running one's-complement sum.
- Presents the final (optionally complemented) checksum on a valid/ready output.
- Sits between a word source and checksum-insert/check logic.

Parameters:
WIDTH, 16, data and accumulator width in bits (minimum 2)
CNT_W, 8, width of the accepted-word counter
INVERT_OUT, 1, 1 = Y is bitwise complement of the sum (checksum form); 0 = raw sum
NORM_ZERO, 1, 1 = raw sum of all-ones (negative zero) is reported as all-zeros before optional inversion

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a new packet; sampled only in IDLE
A  input  WIDTH  data word
A_valid  input  1  A holds a valid word
A_last  input  1  qualifies A as final word of the packet
sub  input  1  per-word mode: 0 = add A, 1 = subtract A (add ~A)
A_ready  output  1  block accepts A this cycle
Y  output  WIDTH  result checksum
Y_valid  output  1  Y is valid
Y_ready  input  1  downstream accepts Y
count  output  CNT_W  words accepted in the current/last packet (saturating)
count_ovf  output  1  count saturated during the packet

Behaviour:
Reset:
- Takes effect on the clk edge while reset=1.
- Sets state=IDLE and acc=0, and clears count, count_ovf, Y_valid and A_ready.
- Y=0 when INVERT_OUT=0, all-ones when INVERT_OUT=1 (Y is always derived from acc).
- Reset mid-packet discards the partial sum. Reset overrides every other input in the same cycle.

States: IDLE, ACCUM, DONE.
- IDLE: A_ready=0, Y_valid=0. When start=1, next state is ACCUM and acc, count and count_ovf are cleared.
- ACCUM: A_ready=1. A transfer happens when A_valid && A_ready.
  - On a transfer: acc <= oc_add(acc, sub ? ~A : A); count increments.
  - If A_last=1 on the transfer, next state is DONE.
  - start is ignored in ACCUM.
- DONE: Y_valid=1 and A_ready=0; Y is stable. When Y_ready=1, next state is IDLE.
  - start in the same cycle as the Y handshake is ignored; a new start must arrive once the block is back in IDLE.

Arithmetic:
- oc_add(x,y): s = x + y computed at WIDTH+1 bits; result = s[WIDTH-1:0] + s[WIDTH].
- The single end-around fold never re-overflows, so the add completes in one cycle.
- Y = f(acc), registered combinationally from acc:
  - t = (NORM_ZERO && acc==all-ones) ? 0 : acc.
  - Y = INVERT_OUT ? ~t : t.

Latency and throughput:
- One word per cycle while A_valid stays high.
- Y_valid asserts the cycle after the A_last transfer.
- Minimum packet is start -> 1 word -> DONE: 3 cycles from start to IDLE with Y_ready held high.

Counter:
- count saturates at 2^CNT_W-1; count_ovf sets on any transfer while saturated and stays set until the next start.
- Accumulation continues correctly regardless of saturation.

Outside ACCUM:
- A_valid, A_last and sub are don't-care outside ACCUM.
- A_last without A_valid has no effect.

Decomposition:
Package ones_comp_pkg:
- state typedef {IDLE, ACCUM, DONE}.
- Function oc_add(a,b) for the end-around add, for reuse by the bench model.

Sub-module ones_comp_adder:
- Parametrised WIDTH, combinational end-around adder (inputs A, B; output Y).
- Built from a full_adder ripple chain plus an end-around carry stage.
- Instantiated once for the accumulator update.

Test Plan:
All cases use WIDTH=4, INVERT_OUT=1, NORM_ZERO=1 unless stated.
- Add pair: start; words 5, 3 (last) -> acc=8, Y=7, Y_valid the cycle after last, count=2.
- End-around carry: words C, 6 (last) -> raw 0x12, folded acc=3, Y=C.
- Subtract: word 5, then 3 with sub=1 (last) -> 5+C=0x11, fold acc=2, Y=D.
- Negative zero: words 5, A (last) -> acc=F. NORM_ZERO=1 gives Y=F; with NORM_ZERO=0 and INVERT_OUT=0, Y=F; with NORM_ZERO=1 and INVERT_OUT=0, Y=0.
- Flow control and back-pressure:
  - A_valid gaps mid-packet leave acc unchanged during the gaps.
  - Y_ready held low 5 cycles in DONE -> Y_valid and Y held, A_ready=0.
  - Y_ready=1 -> IDLE the next cycle; start asserted during DONE is ignored.
- Reset mid-packet plus saturation:
  - reset after 2 of 4 words -> IDLE, count=0, Y_valid=0.
  - New packet of 300 words of 1 with CNT_W=8 -> count=255, count_ovf=1, acc equals the reference model's oc_add fold of all 300 words.
